alarm_multizone: RTL and testbench

//  Parametrised successor to the single-sensor alarm: an N-zone intrusion controller.

---
 rtl/alarm_multizone.sv | 131 +++++++++++++
 tb/tb_alarm_multizone.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/alarm_multizone.sv
// N-zone intrusion controller: exit/entry delays, instant or delayed zones,
// timed siren with optional re-arm, and a sticky record of tripped zones.
module alarm_zone_bit (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    input  logic sensor,
    output logic seen
);
    always_ff @(posedge clk) begin
        if (rst || clr)
            seen <= 1'b0;
        else if (en && sensor)
            seen <= 1'b1;
    end
endmodule

module alarm_multizone #(
    parameter int N_ZONES      = 4,
    parameter int EXIT_CYCLES  = 16,
    parameter int ENTRY_CYCLES = 16,
    parameter int SIREN_CYCLES = 64,
    parameter int REARM        = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               remote,
    input  logic [N_ZONES-1:0] sensors,
    input  logic [N_ZONES-1:0] instant_mask,
    output logic               siren,
    output logic               armed,
    output logic [2:0]         state,
    output logic [N_ZONES-1:0] alarm_zone
);
    localparam int MAX_A = (EXIT_CYCLES > ENTRY_CYCLES) ? EXIT_CYCLES : ENTRY_CYCLES;
    localparam int MAX_C = (MAX_A > SIREN_CYCLES) ? MAX_A : SIREN_CYCLES;
    localparam int CW    = $clog2(MAX_C + 1);

    localparam logic [CW-1:0] EXIT_LOAD  = CW'(EXIT_CYCLES - 1);
    localparam logic [CW-1:0] ENTRY_LOAD = CW'(ENTRY_CYCLES - 1);
    localparam logic [CW-1:0] SIREN_LOAD = CW'(SIREN_CYCLES - 1);

    typedef enum logic [2:0] {
        DISARMED = 3'd0,
        EXIT     = 3'd1,
        ARMED    = 3'd2,
        ENTRY    = 3'd3,
        ALARM    = 3'd4
    } state_t;

    state_t        st;
    logic [CW-1:0] cnt;
    logic          remote_q;
    logic          rem_edge;
    logic          trip_inst;
    logic          trip_any;
    logic          cnt_zero;

    assign rem_edge  = remote & ~remote_q;
    assign trip_inst = |(sensors & instant_mask);
    assign trip_any  = |sensors;
    assign cnt_zero  = (cnt == '0);

    // One shared down-counter; each timed state loads it on entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            st       <= DISARMED;
            cnt      <= '0;
            remote_q <= 1'b1;
        end else begin
            remote_q <= remote;
            case (st)
                DISARMED: begin
                    if (rem_edge) begin
                        st  <= EXIT;
                        cnt <= EXIT_LOAD;
                    end
                end
                EXIT: begin
                    if (rem_edge)      st  <= DISARMED;
                    else if (cnt_zero) st  <= ARMED;
                    else               cnt <= cnt - 1'b1;
                end
                ARMED: begin
                    if (rem_edge) begin
                        st <= DISARMED;
                    end else if (trip_inst) begin
                        st  <= ALARM;
                        cnt <= SIREN_LOAD;
                    end else if (trip_any) begin
                        st  <= ENTRY;
                        cnt <= ENTRY_LOAD;
                    end
                end
                ENTRY: begin
                    if (rem_edge) begin
                        st <= DISARMED;
                    end else if (trip_inst || cnt_zero) begin
                        st  <= ALARM;
                        cnt <= SIREN_LOAD;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ALARM: begin
                    if (rem_edge)      st  <= DISARMED;
                    else if (cnt_zero) st  <= (REARM != 0) ? ARMED : DISARMED;
                    else               cnt <= cnt - 1'b1;
                end
                default: st <= DISARMED;
            endcase
        end
    end

    assign state = st;
    assign siren = (st == ALARM);
    assign armed = (st == ARMED) || (st == ENTRY) || (st == ALARM);

    // Zone record clears only on arming, so it survives disarm for readout.
    for (genvar z = 0; z < N_ZONES; z++) begin : g_zone
        alarm_zone_bit u_zone (
            .clk    (clk),
            .rst    (rst),
            .clr    ((st == DISARMED) && rem_edge),
            .en     (armed),
            .sensor (sensors[z]),
            .seen   (alarm_zone[z])
        );
    end
endmodule

// File: tb/tb_alarm_multizone.sv
// Bench for alarm_multizone: directed scenarios plus random traffic, two
// instances (REARM=1 and REARM=0) checked every cycle against a phase model.
module tb_alarm_multizone;
    localparam int NZ  = 4;
    localparam int EXC = 4;
    localparam int ENC = 3;
    localparam int SIC = 5;

    localparam int S_DIS = 0, S_EXIT = 1, S_ARM = 2, S_ENT = 3, S_ALM = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          remote = 1'b0;
    logic [NZ-1:0] sensors = '0;
    logic [NZ-1:0] mask = 4'b0001;

    logic          siren0, armed0, siren1, armed1;
    logic [2:0]    state0, state1;
    logic [NZ-1:0] az0, az1;

    int tests = 0;
    int fails = 0;

    // Reference model: phase plus cycles elapsed in that phase, per instance.
    int m_st[2];
    int m_el[2];
    int m_az[2];
    bit m_prev[2];

    always #5 clk = ~clk;

    alarm_multizone #(.N_ZONES(NZ), .EXIT_CYCLES(EXC), .ENTRY_CYCLES(ENC),
                      .SIREN_CYCLES(SIC), .REARM(1)) u_dut0 (
        .clk(clk), .rst(rst), .remote(remote), .sensors(sensors),
        .instant_mask(mask), .siren(siren0), .armed(armed0),
        .state(state0), .alarm_zone(az0));

    alarm_multizone #(.N_ZONES(NZ), .EXIT_CYCLES(EXC), .ENTRY_CYCLES(ENC),
                      .SIREN_CYCLES(SIC), .REARM(0)) u_dut1 (
        .clk(clk), .rst(rst), .remote(remote), .sensors(sensors),
        .instant_mask(mask), .siren(siren1), .armed(armed1),
        .state(state1), .alarm_zone(az1));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_st[k] = S_DIS; m_el[k] = 0; m_az[k] = 0; m_prev[k] = 1'b1;
            end else begin
                bit edge_seen;
                bit inst;
                bit any;
                edge_seen = remote && !m_prev[k];
                m_prev[k] = remote;
                inst = |(sensors & mask);
                any  = |sensors;
                if (m_st[k] >= S_ARM) m_az[k] = m_az[k] | int'(sensors);
                case (m_st[k])
                    S_DIS: if (edge_seen) begin m_st[k] = S_EXIT; m_el[k] = 0; m_az[k] = 0; end
                    S_EXIT: begin
                        if (edge_seen) m_st[k] = S_DIS;
                        else begin
                            m_el[k]++;
                            if (m_el[k] == EXC) m_st[k] = S_ARM;
                        end
                    end
                    S_ARM: begin
                        if (edge_seen) m_st[k] = S_DIS;
                        else if (inst) begin m_st[k] = S_ALM; m_el[k] = 0; end
                        else if (any)  begin m_st[k] = S_ENT; m_el[k] = 0; end
                    end
                    S_ENT: begin
                        if (edge_seen) m_st[k] = S_DIS;
                        else if (inst) begin m_st[k] = S_ALM; m_el[k] = 0; end
                        else begin
                            m_el[k]++;
                            if (m_el[k] == ENC) begin m_st[k] = S_ALM; m_el[k] = 0; end
                        end
                    end
                    default: begin
                        if (edge_seen) m_st[k] = S_DIS;
                        else begin
                            m_el[k]++;
                            if (m_el[k] == SIC) m_st[k] = (k == 0) ? S_ARM : S_DIS;
                        end
                    end
                endcase
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        chk("state0", 32'(state0), 32'(m_st[0]));
        chk("siren0", 32'(siren0), 32'(m_st[0] == S_ALM));
        chk("armed0", 32'(armed0), 32'(m_st[0] >= S_ARM));
        chk("zone0",  32'(az0),    32'(m_az[0]));
        chk("state1", 32'(state1), 32'(m_st[1]));
        chk("siren1", 32'(siren1), 32'(m_st[1] == S_ALM));
        chk("armed1", 32'(armed1), 32'(m_st[1] >= S_ARM));
        chk("zone1",  32'(az1),    32'(m_az[1]));
    endtask

    task automatic press();
        remote = 1'b1; tick();
        remote = 1'b0; tick();
    endtask

    task automatic wait_armed0(input string tag);
        for (int i = 0; i < 20 && state0 != 3'(S_ARM); i++) tick();
        chk(tag, 32'(state0), S_ARM);
    endtask

    initial begin
        int n;
        int entries;
        logic [2:0] prev;

        tick(); tick();
        chk("rst_state", 32'(state0), 0);
        chk("rst_siren", 32'(siren0), 0);
        chk("rst_zone",  32'(az0),    0);
        rst = 1'b0; tick();

        // Arm: EXIT for exactly EXC cycles, then ARMED
        remote = 1'b1; tick(); remote = 1'b0;
        n = 0;
        for (int i = 0; i < 20 && state0 == 3'(S_EXIT); i++) begin n++; tick(); end
        chk("exit_len", n, EXC);
        chk("armed_state", 32'(state0), S_ARM);
        chk("armed_out", 32'(armed0), 1);

        // Delayed zone: ENTRY then siren, re-arm after timeout
        sensors = 4'b0100; tick(); sensors = '0;
        n = 0;
        for (int i = 0; i < 20 && state0 == 3'(S_ENT); i++) begin n++; tick(); end
        chk("entry_len", n, ENC);
        n = 0;
        for (int i = 0; i < 20 && siren0; i++) begin n++; tick(); end
        chk("siren_len", n, SIC);
        chk("rearm_state", 32'(state0), S_ARM);
        chk("zone_0100", 32'(az0), 32'h4);
        chk("norearm_state", 32'(state1), S_DIS);

        // Fresh arm, then instant zone and a delayed zone during ALARM
        press();
        chk("disarm", 32'(state0), S_DIS);
        press();
        wait_armed0("rearm_wait");
        sensors = 4'b0001; tick();
        chk("instant_alarm", 32'(state0), S_ALM);
        n = 0;
        for (int i = 0; i < 20 && siren0; i++) begin
            n++;
            sensors = (n == 1) ? 4'b0010 : 4'b0000;
            tick();
        end
        chk("siren_len2", n, SIC);
        chk("zone_0011", 32'(az0), 32'h3);

        // Disarm beats instant trip in the same cycle
        sensors = 4'b0100; tick(); sensors = '0;
        chk("entry_enter", 32'(state0), S_ENT);
        remote = 1'b1; sensors = 4'b0001; tick();
        chk("disarm_wins", 32'(state0), S_DIS);
        chk("no_siren", 32'(siren0), 0);
        remote = 1'b0; sensors = '0; tick();

        // Remote held through reset is not an edge; long hold is one edge
        remote = 1'b1; rst = 1'b1; tick(); rst = 1'b0; tick(); tick();
        chk("held_rst", 32'(state0), S_DIS);
        remote = 1'b0; tick();
        remote = 1'b1; entries = 0; prev = state0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (state0 == 3'(S_EXIT) && prev != 3'(S_EXIT)) entries++;
            prev = state0;
        end
        chk("one_exit", entries, 1);
        chk("held_armed", 32'(state0), S_ARM);
        remote = 1'b0; tick();

        // Reset two cycles into ALARM
        sensors = 4'b0001; tick(); sensors = '0; tick();
        chk("alarm2", 32'(state0), S_ALM);
        rst = 1'b1; tick();
        chk("rst_mid_siren", 32'(siren0), 0);
        chk("rst_mid_state", 32'(state0), 0);
        chk("rst_mid_zone",  32'(az0), 0);
        rst = 1'b0; tick();

        // Random traffic
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 15) == 0) remote = ~remote;
            sensors = ($urandom_range(0, 5) == 0) ? NZ'($urandom) : '0;
            if ($urandom_range(0, 31) == 0) mask = NZ'($urandom);
            rst = ($urandom_range(0, 299) == 0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
